// File: rtl/decode_sb.sv
// Decode stage with a small decoded-instruction FIFO, a register write
// scoreboard and valid/ready issue. Option: DECODE_ILLEGAL_TRAP_EN.
module decode_sb #(
    parameter int OPC_W      = 7,
    parameter int PRIM_W     = 5,
    parameter int SEC_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              isBranch_i,
    input  logic              instructionFormat_i,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [PRIM_W-1:0] primOperand_i,
    input  logic [SEC_W-1:0]  secOperand_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OPC_W-1:0]  opcode_o,
    output logic [1:0]        functionType_o,
    output logic [PRIM_W-1:0] primOperand_o,
    output logic [SEC_W-1:0]  secOperand_o,
    output logic              pRead_o,
    output logic              pWrite_o,
    output logic              sRead_o,
    output logic              hazardStall_o,
    input  logic              wbValid_i,
    input  logic [PRIM_W-1:0] wbReg_i
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic              illegalOp_o
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int NREG = 1 << PRIM_W;

    logic [OPC_W-1:0]  r_op   [FIFO_DEPTH];
    logic [1:0]        r_ty   [FIFO_DEPTH];
    logic [PRIM_W-1:0] r_prim [FIFO_DEPTH];
    logic [SEC_W-1:0]  r_sec  [FIFO_DEPTH];
    logic [2:0]        r_flg  [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [NREG-1:0]   r_busy;

    logic [31:0]       w_opx;
    logic [1:0]        w_dec_ty;
    logic              w_dec_pr;
    logic              w_dec_pw;
    logic              w_dec_sr;
    logic              w_rr;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_haz;
    logic [NREG-1:0]   w_busy_nxt;

    assign w_opx = 32'(opcode_i);
    assign w_rr  = ~instructionFormat_i;

    // Decode table applied to the incoming instruction
    always_comb begin
        w_dec_ty = 2'd0;
        w_dec_pr = 1'b0;
        w_dec_pw = 1'b0;
        w_dec_sr = 1'b0;
        if (isBranch_i) begin
            if (w_opx >= 1 && w_opx <= 8) begin
                w_dec_ty = 2'd2;
                w_dec_pr = 1'b1;
                w_dec_sr = w_rr && (w_opx <= 4);
            end
        end else begin
            unique case (1'b1)
                (w_opx >= 1 && w_opx <= 3): begin
                    w_dec_pr = 1'b1;
                    w_dec_pw = 1'b1;
                    w_dec_sr = w_rr;
                end
                (w_opx == 10 || w_opx == 11): begin
                    w_dec_ty = 2'd1;
                    w_dec_pw = 1'b1;
                    w_dec_sr = w_rr;
                end
                (w_opx == 12): begin
                    w_dec_ty = 2'd1;
                    w_dec_pr = 1'b1;
                    w_dec_sr = w_rr;
                end
                (w_opx >= 20 && w_opx <= (w_rr ? 24 : 25)): begin
                    w_dec_ty = 2'd3;
                    w_dec_sr = w_rr && (w_opx == 24);
                end
                default: begin
                end
            endcase
        end
    end

    assign w_empty    = (r_count == '0);
    assign in_ready_o = (r_count < CW'(FIFO_DEPTH));
    assign w_push     = in_valid_i && in_ready_o && !flush_i;
    assign w_pop      = out_valid_o && out_ready_i;

    assign opcode_o       = w_empty ? '0 : r_op[r_rptr];
    assign functionType_o = w_empty ? '0 : r_ty[r_rptr];
    assign primOperand_o  = w_empty ? '0 : r_prim[r_rptr];
    assign secOperand_o   = w_empty ? '0 : r_sec[r_rptr];
    assign pRead_o        = !w_empty && r_flg[r_rptr][2];
    assign pWrite_o       = !w_empty && r_flg[r_rptr][1];
    assign sRead_o        = !w_empty && r_flg[r_rptr][0];

    assign w_haz = ((pRead_o || pWrite_o) && r_busy[primOperand_o])
                || (sRead_o && r_busy[secOperand_o[PRIM_W-1:0]])
                || (!w_empty && functionType_o == 2'd3 && |r_busy);

    assign out_valid_o   = !w_empty && !w_haz;
    assign hazardStall_o = !w_empty && w_haz;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              r_ill [FIFO_DEPTH];
    logic              w_dec_ill;

    assign w_dec_ill = isBranch_i ? (w_opx > 8) :
        !((w_opx <= 3) || (w_opx >= 10 && w_opx <= 12) ||
          (w_opx >= 20 && w_opx <= (w_rr ? 24 : 25)));
    assign illegalOp_o = !w_empty && r_ill[r_rptr];

    // Illegal marker stored alongside each entry
    always_ff @(posedge clock_i) begin
        if (w_push) r_ill[r_wptr] <= w_dec_ill;
    end
`endif

    // Entry storage; occupancy gates the head, so no reset needed
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_op[r_wptr]   <= opcode_i;
            r_ty[r_wptr]   <= w_dec_ty;
            r_prim[r_wptr] <= primOperand_i;
            r_sec[r_wptr]  <= secOperand_i;
            r_flg[r_wptr]  <= {w_dec_pr, w_dec_pw, w_dec_sr};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Scoreboard next state: writeback clears, issued writer sets (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (wbValid_i) w_busy_nxt[wbReg_i] = 1'b0;
        if (w_pop && pWrite_o) w_busy_nxt[primOperand_o] = 1'b1;
    end

    // Scoreboard register; flush leaves in-flight writers tracked
    always_ff @(posedge clock_i) begin
        if (reset_i) r_busy <= '0;
        else         r_busy <= w_busy_nxt;
    end
endmodule

// File: tb/tb_decode_sb.sv
// Testbench for decode_sb: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_decode_sb;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, br, fmt;
    logic [6:0]  op;
    logic [4:0]  prim;
    logic [15:0] sec;
    logic        out_ready, wb_valid;
    logic [4:0]  wb_reg;
    logic        in_ready, out_valid, pr_o, pw_o, sr_o, stall;
    logic [6:0]  op_o;
    logic [1:0]  ft_o;
    logic [4:0]  prim_o;
    logic [15:0] sec_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ill_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_sb dut (
        .clock_i(clk), .reset_i(reset), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .isBranch_i(br), .instructionFormat_i(fmt),
        .opcode_i(op), .primOperand_i(prim), .secOperand_i(sec),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .opcode_o(op_o), .functionType_o(ft_o),
        .primOperand_o(prim_o), .secOperand_o(sec_o),
        .pRead_o(pr_o), .pWrite_o(pw_o), .sRead_o(sr_o),
        .hazardStall_o(stall), .wbValid_i(wb_valid), .wbReg_i(wb_reg)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .illegalOp_o(ill_o)
`endif
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [1:0]  ty;
        logic [4:0]  p;
        logic [15:0] s;
        logic        pr, pw, sr, ill;
    } ent_t;

    ent_t        q[$];
    logic [31:0] busy;

    function automatic ent_t ref_decode(logic b, logic imm, logic [6:0] o,
                                        logic [4:0] p, logic [15:0] s);
        ent_t e;
        int   n;
        e = '0;
        e.op = o; e.p = p; e.s = s;
        n = int'(o);
        if (b) begin
            if (n >= 1 && n <= 8) begin
                e.ty = 2; e.pr = 1; e.sr = !imm && n <= 4;
            end else if (n != 0) e.ill = 1;
        end else if (n >= 1 && n <= 3) begin
            e.pr = 1; e.pw = 1; e.sr = !imm;
        end else if (n == 10 || n == 11) begin
            e.ty = 1; e.pw = 1; e.sr = !imm;
        end else if (n == 12) begin
            e.ty = 1; e.pr = 1; e.sr = !imm;
        end else if (n >= 20 && n <= (imm ? 25 : 24)) begin
            e.ty = 3; e.sr = !imm && n == 24;
        end else if (n != 0) e.ill = 1;
        return e;
    endfunction

    function automatic bit ref_haz();
        ent_t h;
        if (q.size() == 0) return 0;
        h = q[0];
        return ((h.pr || h.pw) && busy[h.p]) || (h.sr && busy[h.s[4:0]])
            || (h.ty == 3 && busy != 0);
    endfunction

    function automatic ent_t ref_head();
        if (q.size() == 0) return '0;
        return q[0];
    endfunction

    task automatic model_step();
        int   sz;
        bit   iss;
        ent_t h;
        if (reset) begin
            q.delete();
            busy = 0;
        end else begin
            sz  = q.size();
            iss = sz > 0 && !ref_haz() && out_ready;
            if (wb_valid) busy[wb_reg] = 1'b0;
            if (iss) begin
                h = q.pop_front();
                if (h.pw) busy[h.p] = 1'b1;
            end
            if (flush) q.delete();
            else if (in_valid && sz < 2)
                q.push_back(ref_decode(br, fmt, op, prim, sec));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic push(logic b, logic f, int o, int p, int s);
        in_valid = 1; br = b; fmt = f;
        op = 7'(o); prim = 5'(p); sec = 16'(s);
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_valid = 0; wb_reg = 0;
        br = 0; fmt = 0; op = 0; prim = 0; sec = 0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1; out_ready = 0;
        cycle(); cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; out_ready = 1;
        push(0, 0, 1, 3, 5);
        cycle(); cycle();
        reset = 0; in_valid = 0;
        n_vec++;
        if ({in_ready, out_valid, stall} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 100",
                     {in_ready, out_valid, stall});
        end
        n_vec++;
        if ({op_o, ft_o, prim_o, sec_o, pr_o, pw_o, sr_o} !== '0) begin
            n_err++;
            $display("FAIL reset_head: got op %0d ty %0d p %0d s %0d fl %b",
                     op_o, ft_o, prim_o, sec_o, {pr_o, pw_o, sr_o});
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_vec++;
        if (ill_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ill: got %b want 0", ill_o);
        end
`endif
    endtask

    task automatic test_raw_hazard();
        apply_reset();
        out_ready = 1;
        push(0, 0, 1, 3, 5);
        cycle();
        in_valid = 0;
        n_vec++;
        if ({out_valid, ft_o, pr_o, pw_o, sr_o, prim_o, sec_o}
            !== {1'b1, 2'd0, 3'b111, 5'd3, 16'd5}) begin
            n_err++;
            $display("FAIL add_head: v %b ty %0d fl %b p %0d s %0d want 1 0 111 3 5",
                     out_valid, ft_o, {pr_o, pw_o, sr_o}, prim_o, sec_o);
        end
        cycle();
        push(0, 1, 1, 3, 0);
        cycle();
        in_valid = 0;
        n_vec++;
        if ({stall, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL raw_stall: got %b want 10", {stall, out_valid});
        end
        cycle();
        n_vec++;
        if ({stall, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL raw_hold: got %b want 10", {stall, out_valid});
        end
        wb_valid = 1; wb_reg = 3;
        cycle();
        wb_valid = 0;
        n_vec++;
        if ({stall, out_valid, pr_o, pw_o, sr_o} !== 5'b01110) begin
            n_err++;
            $display("FAIL raw_release: got %b want 01110",
                     {stall, out_valid, pr_o, pw_o, sr_o});
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 0;
        push(0, 0, 10, 1, 0);
        cycle();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready1: got %b want 1", in_ready);
        end
        push(0, 1, 12, 2, 0);
        cycle();
        n_vec++;
        if ({in_ready, out_valid, op_o} !== {2'b01, 7'd10}) begin
            n_err++;
            $display("FAIL bp_full: rdy %b v %b op %0d want 0 1 10",
                     in_ready, out_valid, op_o);
        end
        push(0, 0, 2, 4, 0);
        cycle();
        in_valid = 0;
        out_ready = 1;
        cycle();
        n_vec++;
        if ({out_valid, op_o} !== {1'b1, 7'd12}) begin
            n_err++;
            $display("FAIL bp_second: v %b op %0d want 1 12", out_valid, op_o);
        end
        cycle();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_drain: got %b want 01 (third dropped)",
                     {out_valid, in_ready});
        end
    endtask

    task automatic test_serialise();
        apply_reset();
        out_ready = 1;
        push(0, 1, 1, 7, 0);
        cycle();
        in_valid = 0;
        cycle();
        push(0, 1, 20, 0, 0);
        cycle();
        in_valid = 0;
        n_vec++;
        if ({stall, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL ser_stall: got %b want 10", {stall, out_valid});
        end
        wb_valid = 1; wb_reg = 7;
        cycle();
        wb_valid = 0;
        n_vec++;
        if ({out_valid, stall, ft_o, pr_o, pw_o, sr_o} !== 7'b1011000) begin
            n_err++;
            $display("FAIL ser_issue: got %b want 1011000",
                     {out_valid, stall, ft_o, pr_o, pw_o, sr_o});
        end
        cycle();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ser_pop: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1;
        push(0, 1, 1, 9, 0);
        cycle();
        in_valid = 0;
        cycle();
        out_ready = 0;
        push(0, 1, 11, 1, 0);
        cycle();
        push(0, 1, 12, 2, 0);
        cycle();
        push(0, 1, 3, 5, 0);
        flush = 1;
        cycle();
        flush = 0; in_valid = 0;
        n_vec++;
        if ({out_valid, stall, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL flush_empty: got %b want 001",
                     {out_valid, stall, in_ready});
        end
        out_ready = 1;
        push(0, 1, 12, 9, 0);
        cycle();
        in_valid = 0;
        n_vec++;
        if ({stall, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_keepsb: got %b want 10", {stall, out_valid});
        end
        wb_valid = 1; wb_reg = 9;
        cycle();
        wb_valid = 0;
        n_vec++;
        if ({out_valid, op_o} !== {1'b1, 7'd12}) begin
            n_err++;
            $display("FAIL flush_wb: v %b op %0d want 1 12", out_valid, op_o);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        out_ready = 1;
        push(0, 1, 1, 4, 0);
        cycle();
        in_valid = 0;
        cycle();
        push(0, 1, 50, 4, 4);
        cycle();
        in_valid = 0;
        n_vec++;
        if ({out_valid, stall, op_o, ft_o, pr_o, pw_o, sr_o}
            !== {2'b10, 7'd50, 2'd0, 3'b000}) begin
            n_err++;
            $display("FAIL ill_head: v %b st %b op %0d ty %0d fl %b want 1 0 50 0 000",
                     out_valid, stall, op_o, ft_o, {pr_o, pw_o, sr_o});
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_vec++;
        if (ill_o !== 1'b1) begin
            n_err++;
            $display("FAIL ill_flag: got %b want 1", ill_o);
        end
`endif
        cycle();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ill_pop: got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        ent_t e;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            reset     = $urandom_range(0, 199) == 0;
            flush     = $urandom_range(0, 99) < 3;
            in_valid  = $urandom_range(0, 99) < 60;
            br        = $urandom_range(0, 3) == 0;
            fmt       = 1'($urandom_range(0, 1));
            op        = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 26))
                                                   : 7'($urandom_range(0, 127));
            prim      = 5'($urandom_range(0, 7));
            sec       = {11'($urandom), 5'($urandom_range(0, 7))};
            out_ready = !flush && $urandom_range(0, 99) < 70;
            wb_valid  = $urandom_range(0, 99) < 30;
            wb_reg    = 5'($urandom_range(0, 7));
            cycle();
            e = ref_head();
            n_vec++;
            if ({in_ready, out_valid, stall} !==
                {q.size() < 2, q.size() > 0 && !ref_haz(), ref_haz()}) begin
                n_err++;
                $display("FAIL rnd_ctrl @%0d: got %b want %b", i,
                         {in_ready, out_valid, stall},
                         {q.size() < 2, q.size() > 0 && !ref_haz(), ref_haz()});
            end
            n_vec++;
            if ({op_o, ft_o, prim_o, sec_o, pr_o, pw_o, sr_o} !==
                {e.op, e.ty, e.p, e.s, e.pr, e.pw, e.sr}) begin
                n_err++;
                $display("FAIL rnd_head @%0d: got %h want %h", i,
                         {op_o, ft_o, prim_o, sec_o, pr_o, pw_o, sr_o},
                         {e.op, e.ty, e.p, e.s, e.pr, e.pw, e.sr});
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            n_vec++;
            if (ill_o !== e.ill) begin
                n_err++;
                $display("FAIL rnd_ill @%0d: got %b want %b", i, ill_o, e.ill);
            end
`endif
        end
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1; out_ready = 0;
        busy = 0;
        test_reset();
        test_raw_hazard();
        test_backpressure();
        test_serialise();
        test_flush();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_sb.md
Name: decode_sb

Overview:
- Parametrised successor of the single-register decode stage.
- Classifies incoming instructions (branch/format/opcode) into function type and operand read/write flags, buffers them in a small FIFO, and issues them over a valid/ready handshake.
- Holds back any instruction with a register hazard using an internal write scoreboard.
- Sits between fetch and the register-read/execute stage; replaces the old global-stall input with per-stage backpressure.

Parameters:
- OPC_W, 7, opcode width.
- PRIM_W, 5, primary operand / register index width; scoreboard has 2**PRIM_W entries.
- SEC_W, 16, secondary operand width (SEC_W >= PRIM_W).
- FIFO_DEPTH, 2, decoded-instruction buffer entries; power of two, >= 2.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all buffered, unissued instructions.
- in_valid_i  in  1  fetch presents an instruction.
- in_ready_o  out  1  FIFO not full.
- isBranch_i  in  1  branch class.
- instructionFormat_i  in  1  1 = reg-imm, 0 = reg-reg.
- opcode_i  in  OPC_W  opcode.
- primOperand_i  in  PRIM_W  primary operand.
- secOperand_i  in  SEC_W  secondary operand.
- out_valid_o  out  1  head entry present and hazard-free.
- out_ready_i  in  1  downstream accepts.
- opcode_o  out  OPC_W  head opcode.
- functionType_o  out  2  0 arith, 1 load/store, 2 branch, 3 reg-frame.
- primOperand_o  out  PRIM_W  head primary operand.
- secOperand_o  out  SEC_W  head secondary operand.
- pRead_o, pWrite_o, sRead_o  out  1 each  head operand flags.
- hazardStall_o  out  1  head present but blocked by the scoreboard.
- wbValid_i  in  1  writeback completes.
- wbReg_i  in  PRIM_W  register written back.

Behaviour:
- Accept: in_valid_i && in_ready_o on a rising edge. The decode table is applied combinationally to the inputs and the result is written into the FIFO tail.
- Decode table, branch:
  - op 0 → nop: type 0, no flags.
  - op 1-8 → type 2, pRead=1.
  - sRead=1 only for reg-reg format with op 1-4.
- Decode table, non-branch:
  - op 0 → nop.
  - op 1-3 → type 0, pRead=1, pWrite=1.
  - op 10, 11 → type 1, pWrite=1.
  - op 12 → type 1, pRead=1.
  - op 20-25 (reg-imm) / 20-24 (reg-reg) → type 3, no prim flags.
  - sRead=1 for reg-reg format on op 1-3 and 10-12, and for reg-reg op 24.
- Unlisted opcodes: see Optional Feature.
- Latency: an instruction accepted into an empty FIFO is visible at the head the cycle after the accepting edge. Head outputs come directly from FIFO registers.
- Issue: out_valid_o && out_ready_i; pops the head. Simultaneous accept and issue when full is not allowed; in_ready_o depends only on occupancy (count < FIFO_DEPTH).
- Hazard on head, when any of these holds:
  - pRead && busy[prim].
  - pWrite && busy[prim] (WAW).
  - sRead && busy[sec[PRIM_W-1:0]].
  - type 3 && any busy bit set (serialising).
- On hazard: out_valid_o=0, hazardStall_o=1.
- Scoreboard:
  - Issue with pWrite sets busy[prim].
  - wbValid_i clears busy[wbReg_i].
  - Same register set and cleared in one cycle: set wins.
  - wbValid_i for a non-busy register: no effect.
- Flush: count←0, pointers←0 on the edge. An accept in the same cycle is dropped. Scoreboard is NOT cleared (issued writers still write back).
- Reset, on the edge, overrides flush:
  - FIFO emptied; all busy bits cleared.
  - out_valid_o=0, hazardStall_o=0, in_ready_o=1.
  - opcode_o/operand outputs 0, functionType_o=0, flags 0.
- FIFO pointers wrap modulo FIFO_DEPTH. When empty, head outputs read as zero.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegalOp_o (1 bit).
  - An unlisted opcode is stored with illegal=1, type 0, all flags 0.
  - It issues normally with illegalOp_o=1 and is never hazard-blocked.
  - Reset value of illegalOp_o is 0.
- Undefined: port absent; unlisted opcodes decode and issue as nop.

Test Plan:
- Reset, then reg-reg add (branch=0, fmt=0, op 1, prim 3, sec 5) with out_ready_i=1 → next cycle out_valid_o=1, type 0, pRead=pWrite=sRead=1. After issue busy[3]=1.
- Then reg-imm add op 1 prim 3 → head held: hazardStall_o=1, out_valid_o=0. Assert wbValid_i with wbReg_i=3 → issues the following cycle.
- out_ready_i=0, push 3 instructions with FIFO_DEPTH=2 → in_ready_o=0 after the 2nd accept; the 3rd is not accepted. Release → in-order issue of both.
- Busy[7] set, head is reg-imm op 20 → blocked until wbReg_i=7 retires. Then type 3 issues with no flags.
- Two buffered entries, flush_i=1 with in_valid_i=1 → count 0, out_valid_o=0 next cycle, busy bits unchanged.
- Reg-imm op 50 → with DECODE_ILLEGAL_TRAP_EN: illegalOp_o=1, flags 0. Without the macro: issues as nop.
